sprite_line_renderer: RTL

- Consumes the per-line sprite list produced by the line preparation stage: 32 entries, each {oam_index, valid}.
- For each listed sprite it re-reads the OAM entry, fetches the matching 16-pixel sprite row from sprite memory, and writes the non-transparent pixels into the sprite line buffer.
- It sits between the sprite-list stage and the double-buffered line buffer. The line buffer's scan-out side clears entries after display, so this block never clears it.

---
 rtl/madnes_sprite_pkg.sv | 35 +++
 rtl/sprite_pixel_select.sv | 27 ++
 rtl/sprite_line_renderer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/madnes_sprite_pkg.sv
// Shared types and constants for the sprite line renderer.
// Optional build macro: SPRITE_PRIORITY_EN (routes the OAM priority bit to the line buffer).
package madnes_sprite_pkg;

   localparam int SPRITE_SIZE       = 16;
   localparam int PIXEL_W_DEF       = 4;
   localparam int OAM_ADDR_SIZE_DEF = 6;
   localparam int MAX_OBJ_DEF       = 32;
   localparam int LINE_WIDTH_DEF    = 640;

   typedef struct packed {
      logic       enable;
      logic       yflip;
      logic       xflip;
      logic       prio;
      logic [9:0] ypos;
      logic [9:0] xpos;
      logic [7:0] spriteref;
   } oam_entry_t;

   typedef struct packed {
      logic [OAM_ADDR_SIZE_DEF-1:0] oam_index;
      logic                         valid;
   } list_entry_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      OAM_RD = 3'd2,
      SPR_RD = 3'd3,
      DRAW   = 3'd4,
      DONE   = 3'd5
   } render_state_t;

endpackage

// File: rtl/sprite_pixel_select.sv
// Picks one pixel of a fetched sprite row and decides whether it lands on the visible line.
module sprite_pixel_select
   import madnes_sprite_pkg::*;
#(
   parameter int PIXEL_W    = PIXEL_W_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
   input  logic [SPRITE_SIZE*PIXEL_W-1:0] row_data,
   input  logic [3:0]                     i,
   input  logic                           xflip,
   input  logic [9:0]                     xpos,
   output logic [PIXEL_W-1:0]             colour,
   output logic [10:0]                    x,
   output logic                           write_ok
);

   logic [3:0] p_s;

   // Source pixel, screen x (11 bits so the right edge never wraps) and write eligibility.
   always_comb begin
      p_s      = xflip ? (4'd15 - i) : i;
      colour   = row_data[p_s*PIXEL_W +: PIXEL_W];
      x        = {1'b0, xpos} + {7'd0, i};
      write_ok = (colour != {PIXEL_W{1'b0}}) && (x < 11'(LINE_WIDTH));
   end

endmodule

// File: rtl/sprite_line_renderer.sv
// Walks the per-line sprite list high-to-low, fetches OAM and sprite rows, paints the line buffer.
// Optional build macro: SPRITE_PRIORITY_EN.
module sprite_line_renderer
   import madnes_sprite_pkg::*;
#(
   parameter int MAX_OBJ_PER_LINE = MAX_OBJ_DEF,
   parameter int OAM_ADDR_SIZE    = OAM_ADDR_SIZE_DEF,
   parameter int PIXEL_W          = PIXEL_W_DEF,
   parameter int LINE_WIDTH       = LINE_WIDTH_DEF
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [9:0]                                   sx,
   input  logic [9:0]                                   sy,
   input  logic                                         line_prepared,
   input  logic [MAX_OBJ_PER_LINE*(OAM_ADDR_SIZE+1)-1:0] buffer_array,
   output logic [OAM_ADDR_SIZE-1:0]                     oam_addr,
   input  logic [31:0]                                  oam_data,
   output logic [11:0]                                  spr_addr,
   input  logic [SPRITE_SIZE*PIXEL_W-1:0]               spr_data,
   output logic                                         lb_we,
   output logic [9:0]                                   lb_addr,
   output logic [PIXEL_W:0]                             lb_data,
   output logic                                         busy,
   output logic                                         render_done
);

   localparam int ENTRY_W = OAM_ADDR_SIZE + 1;
   localparam int IDX_W   = $clog2(MAX_OBJ_PER_LINE);

   render_state_t                                 state_r;
   logic [MAX_OBJ_PER_LINE*ENTRY_W-1:0]           list_r;
   logic [9:0]                                    sy_snap_r;
   logic [IDX_W-1:0]                              idx_r;
   logic                                          lp_d_r;
   logic                                          skip_r;
   logic [3:0]                                    pix_r;
   logic [9:0]                                    xpos_r;
   logic                                          xflip_r;
   logic                                          busy_r;
   logic                                          done_r;
   logic                                          lb_we_r;
   logic [9:0]                                    lb_addr_r;
   logic [PIXEL_W:0]                              lb_data_r;
   logic [OAM_ADDR_SIZE-1:0]                      oam_addr_r;
   logic [11:0]                                   spr_addr_r;
`ifdef SPRITE_PRIORITY_EN
   logic                                          prio_r;
`endif

   oam_entry_t                                    oam_s;
   logic [9:0]                                    row_s;
   logic [3:0]                                    row_sel_s;
   logic [IDX_W-1:0]                              idx_dec_s;
   logic                                          entry_valid_s;
   logic [OAM_ADDR_SIZE-1:0]                      next_oam_s;
   logic                                          start_s;
   logic                                          abort_s;
   logic                                          advance_s;
   logic [PIXEL_W-1:0]                            colour_s;
   logic [10:0]                                   x_s;
   logic                                          write_ok_s;
   logic                                          unused_s;

`ifdef SPRITE_PRIORITY_EN
   assign unused_s = ^sx;
`else
   assign unused_s = ^{sx, oam_data[28]};
`endif

   sprite_pixel_select #(
      .PIXEL_W    (PIXEL_W),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_pixel_select (
      .row_data (spr_data),
      .i        (pix_r),
      .xflip    (xflip_r),
      .xpos     (xpos_r),
      .colour   (colour_s),
      .x        (x_s),
      .write_ok (write_ok_s)
   );

   // List decode, row arithmetic and sequencing decisions.
   always_comb begin
      oam_s         = oam_entry_t'(oam_data);
      row_s         = sy_snap_r - oam_s.ypos;
      row_sel_s     = oam_s.yflip ? (4'd15 - row_s[3:0]) : row_s[3:0];
      idx_dec_s     = idx_r - IDX_W'(1);
      entry_valid_s = list_r[idx_r*ENTRY_W];
      next_oam_s    = list_r[idx_dec_s*ENTRY_W + 1 +: OAM_ADDR_SIZE];
      start_s       = line_prepared && !lp_d_r && ((state_r == IDLE) || (state_r == DONE));
      abort_s       = busy_r && (state_r != DONE) && (sy != sy_snap_r);
      case (state_r)
         SELECT:  advance_s = !entry_valid_s;
         SPR_RD:  advance_s = skip_r;
         DRAW:    advance_s = (pix_r == 4'd15);
         default: advance_s = 1'b0;
      endcase
   end

   // Renderer FSM; every output is a register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         list_r     <= '0;
         sy_snap_r  <= 10'd0;
         idx_r      <= '0;
         lp_d_r     <= 1'b0;
         skip_r     <= 1'b0;
         pix_r      <= 4'd0;
         xpos_r     <= 10'd0;
         xflip_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         lb_we_r    <= 1'b0;
         lb_addr_r  <= 10'd0;
         lb_data_r  <= '0;
         oam_addr_r <= '0;
         spr_addr_r <= 12'd0;
`ifdef SPRITE_PRIORITY_EN
         prio_r     <= 1'b0;
`endif
      end else begin
         lp_d_r  <= line_prepared;
         lb_we_r <= 1'b0;
         if (abort_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
         end else if (start_s) begin
            list_r     <= buffer_array;
            sy_snap_r  <= sy;
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            idx_r      <= IDX_W'(MAX_OBJ_PER_LINE - 1);
            oam_addr_r <= buffer_array[(MAX_OBJ_PER_LINE-1)*ENTRY_W + 1 +: OAM_ADDR_SIZE];
            state_r    <= SELECT;
         end else if (advance_s) begin
            // oam_addr is preloaded here so OAM data is ready when the next entry reaches OAM_RD
            if (idx_r == '0) begin
               state_r <= DONE;
            end else begin
               idx_r      <= idx_dec_s;
               oam_addr_r <= next_oam_s;
               state_r    <= SELECT;
            end
            if (state_r == DRAW) begin
               lb_we_r   <= write_ok_s;
               lb_addr_r <= x_s[9:0];
`ifdef SPRITE_PRIORITY_EN
               lb_data_r <= {prio_r, colour_s};
`else
               lb_data_r <= {1'b0, colour_s};
`endif
            end
         end else begin
            case (state_r)
               SELECT: state_r <= OAM_RD;
               OAM_RD: begin
                  xpos_r  <= oam_s.xpos;
                  xflip_r <= oam_s.xflip;
`ifdef SPRITE_PRIORITY_EN
                  prio_r  <= oam_s.prio;
`endif
                  if (!oam_s.enable || (row_s >= 10'd16)) begin
                     skip_r <= 1'b1;
                  end else begin
                     skip_r     <= 1'b0;
                     spr_addr_r <= {oam_s.spriteref, row_sel_s};
                  end
                  state_r <= SPR_RD;
               end
               SPR_RD: begin
                  pix_r   <= 4'd0;
                  state_r <= DRAW;
               end
               DRAW: begin
                  // spr_addr is held through DRAW, so the sprite memory output stays stable
                  lb_we_r   <= write_ok_s;
                  lb_addr_r <= x_s[9:0];
`ifdef SPRITE_PRIORITY_EN
                  lb_data_r <= {prio_r, colour_s};
`else
                  lb_data_r <= {1'b0, colour_s};
`endif
                  pix_r     <= pix_r + 4'd1;
               end
               DONE: begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
               IDLE:    state_r <= IDLE;
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign oam_addr    = oam_addr_r;
   assign spr_addr    = spr_addr_r;
   assign lb_we       = lb_we_r;
   assign lb_addr     = lb_addr_r;
   assign lb_data     = lb_data_r;
   assign busy        = busy_r;
   assign render_done = done_r;

endmodule
